// File: rtl/types_pkg.sv
// Shared types and default timing constants for the frame-grabber / detector
// loopback emulator.
package types_pkg;
   localparam int CLOCK_PERIOD_NS       = 5;
   localparam int FG_PERIOD_DEFAULT     = 2_000_000;
   localparam int FG_OPTO_LEN_DEFAULT   = 200;
   localparam int FG_OPEN_DELAY_DEFAULT = 20_000;
   localparam int FG_OPEN_LEN_DEFAULT   = 1_000_000;
   localparam int DET_PROLONG_DEFAULT   = 1_280_000;

   typedef enum logic [2:0] {
      FG_IDLE,
      FG_OPTO,
      FG_GAP,
      FG_OPEN,
      FG_TAIL
   } fg_emu_state_t;

   typedef enum logic {
      DET_READY,
      DET_BUSY
   } det_emu_state_t;
endpackage

// File: rtl/detector_busy_model.sv
// Detector emulation: trigger edge detect, ready/busy FSM with prolong
// down-counter, accepted and missed trigger counters.
//
// state     | meaning
// DET_READY | accepting triggers, detector_ready high
// DET_BUSY  | prolong counter running, triggers counted as missed
module detector_busy_model
   import types_pkg::*;
#(
   parameter int CNT_W           = 32,
   parameter int DET_PROLONG_CYC = DET_PROLONG_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_signal,
   input  logic        trigger_in,
   output logic        detector_ready,
   output logic [15:0] trigger_count,
   output logic [15:0] missed_count
);
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(DET_PROLONG_CYC - 1);

   det_emu_state_t   det_state_q, det_state_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic             trig_prev_q, trig_prev_d;
   logic             ready_q, ready_d;
   logic [15:0]      trig_cnt_q, trig_cnt_d;
   logic [15:0]      miss_cnt_q, miss_cnt_d;
   logic             trig_edge;

   always_comb begin
      det_state_d = det_state_q;
      busy_cnt_d  = busy_cnt_q;
      ready_d     = ready_q;
      trig_cnt_d  = trig_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      trig_prev_d = trigger_in;
      trig_edge   = trigger_in & ~trig_prev_q;
      case (det_state_q)
         DET_READY: begin
            if (trig_edge) begin
               det_state_d = DET_BUSY;
               busy_cnt_d  = BUSY_LOAD;
               ready_d     = 1'b0;
               trig_cnt_d  = trig_cnt_q + 16'd1;
            end
         end
         DET_BUSY: begin
            // the terminal-count cycle still belongs to the busy window
            if (trig_edge && (miss_cnt_q != 16'hFFFF))
               miss_cnt_d = miss_cnt_q + 16'd1;
            if (busy_cnt_q == '0) begin
               det_state_d = DET_READY;
               ready_d     = 1'b1;
            end else begin
               busy_cnt_d = busy_cnt_q - 1'b1;
            end
         end
         default: begin
            det_state_d = DET_READY;
            ready_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset_signal) begin
      if (reset_signal) begin
         det_state_q <= DET_READY;
         busy_cnt_q  <= '0;
         trig_prev_q <= 1'b1;
         ready_q     <= 1'b1;
         trig_cnt_q  <= '0;
         miss_cnt_q  <= '0;
      end else begin
         det_state_q <= det_state_d;
         busy_cnt_q  <= busy_cnt_d;
         trig_prev_q <= trig_prev_d;
         ready_q     <= ready_d;
         trig_cnt_q  <= trig_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign detector_ready = ready_q;
   assign trigger_count  = trig_cnt_q;
   assign missed_count   = miss_cnt_q;
endmodule

// File: rtl/fg_detector_emulator.sv
// Far-end responder for the calibration scenario FSMs: periodic frame-grabber
// strobe and exposure window, plus the detector busy model.
//
// state   | meaning
// FG_IDLE | disabled, outputs low
// FG_OPTO | fg_opto strobe at frame start
// FG_GAP  | waiting for exposure window
// FG_OPEN | fg_open window active
// FG_TAIL | remainder of frame period
module fg_detector_emulator
   import types_pkg::*;
#(
   parameter int FG_PERIOD_CYC     = FG_PERIOD_DEFAULT,
   parameter int FG_OPTO_LEN       = FG_OPTO_LEN_DEFAULT,
   parameter int FG_OPEN_DELAY_CYC = FG_OPEN_DELAY_DEFAULT,
   parameter int FG_OPEN_LEN       = FG_OPEN_LEN_DEFAULT,
   parameter int DET_PROLONG_CYC   = DET_PROLONG_DEFAULT,
   parameter int CNT_W             = 32
) (
   input  logic        clock,
   input  logic        reset_signal,
   input  logic        enable,
   input  logic        trigger_in,
   output logic        fg_opto,
   output logic        fg_open,
   output logic        detector_ready,
   output logic [15:0] trigger_count,
   output logic [15:0] missed_count
);
   localparam logic [CNT_W-1:0] OPTO_END   = CNT_W'(FG_OPTO_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(FG_OPEN_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] OPEN_END   = CNT_W'(FG_OPEN_DELAY_CYC + FG_OPEN_LEN - 1);
   localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(FG_PERIOD_CYC - 1);

   localparam bit PARAMS_OK = (FG_OPTO_LEN >= 1) && (FG_OPEN_DELAY_CYC >= 1) &&
                              (FG_OPEN_LEN >= 1) && (FG_PERIOD_CYC >= 1) &&
                              (DET_PROLONG_CYC >= 1) &&
                              (FG_OPTO_LEN < FG_OPEN_DELAY_CYC) &&
                              (FG_OPEN_DELAY_CYC + FG_OPEN_LEN < FG_PERIOD_CYC);

   param_check: assert property (@(posedge clock) PARAMS_OK);

   fg_emu_state_t    fg_state_q, fg_state_d;
   logic [CNT_W-1:0] p_q, p_d;
   logic             fg_opto_q, fg_opto_d;
   logic             fg_open_q, fg_open_d;

   always_comb begin
      fg_state_d = fg_state_q;
      p_d        = p_q + 1'b1;
      fg_opto_d  = fg_opto_q;
      fg_open_d  = fg_open_q;
      if (!enable) begin
         // abort the frame outright; no partial window completion
         fg_state_d = FG_IDLE;
         p_d        = '0;
         fg_opto_d  = 1'b0;
         fg_open_d  = 1'b0;
      end else begin
         case (fg_state_q)
            FG_IDLE: begin
               fg_state_d = FG_OPTO;
               p_d        = '0;
               fg_opto_d  = 1'b1;
            end
            FG_OPTO: if (p_q == OPTO_END) begin
               fg_state_d = FG_GAP;
               fg_opto_d  = 1'b0;
            end
            FG_GAP: if (p_q == GAP_END) begin
               fg_state_d = FG_OPEN;
               fg_open_d  = 1'b1;
            end
            FG_OPEN: if (p_q == OPEN_END) begin
               fg_state_d = FG_TAIL;
               fg_open_d  = 1'b0;
            end
            FG_TAIL: if (p_q == PERIOD_END) begin
               fg_state_d = FG_OPTO;
               p_d        = '0;
               fg_opto_d  = 1'b1;
            end
            default: begin
               fg_state_d = FG_IDLE;
               p_d        = '0;
               fg_opto_d  = 1'b0;
               fg_open_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset_signal) begin
      if (reset_signal) begin
         fg_state_q <= FG_IDLE;
         p_q        <= '0;
         fg_opto_q  <= 1'b0;
         fg_open_q  <= 1'b0;
      end else begin
         fg_state_q <= fg_state_d;
         p_q        <= p_d;
         fg_opto_q  <= fg_opto_d;
         fg_open_q  <= fg_open_d;
      end
   end

   assign fg_opto = fg_opto_q;
   assign fg_open = fg_open_q;

   detector_busy_model #(
      .CNT_W           (CNT_W),
      .DET_PROLONG_CYC (DET_PROLONG_CYC)
   ) u_det (
      .clock          (clock),
      .reset_signal   (reset_signal),
      .trigger_in     (trigger_in),
      .detector_ready (detector_ready),
      .trigger_count  (trigger_count),
      .missed_count   (missed_count)
   );
endmodule
